// File: rtl/data_memory.sv
// Load/store data memory with fixed access latency, sub-word accesses and a single
// LR/SC reservation. Requests are latched in IDLE and performed on the WAIT->RESP edge.
module data_memory #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [2:0]  func3,
    input  logic [31:0] address,
    input  logic [31:0] writeData,
    input  logic        reserve,
    input  logic        storeConditional,
    output logic [31:0] readData,
    output logic        busy,
    output logic        done,
    output logic        misaligned
);

    localparam int unsigned IdxW = $clog2(DEPTH_WORDS);
    localparam int unsigned CntW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CntW-1:0] CntInit = CntW'(LATENCY - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]      r_state;
    logic [CntW-1:0] r_count;
    logic            r_is_read;
    logic            r_is_write;
    logic [2:0]      r_func3;
    logic [IdxW-1:0] r_idx;
    logic [1:0]      r_lane;
    logic [31:0]     r_wdata;
    logic            r_reserve;
    logic            r_sc;
    logic            r_res_valid;
    logic [IdxW-1:0] r_res_addr;
    logic [31:0]     r_rdata;
    logic            r_done;
    logic [31:0]     r_mem [DEPTH_WORDS];

    logic            w_req;
    logic            w_addr_bad;
    logic            w_accept;
    logic            w_access;
    logic            w_sc_op;
    logic            w_sc_ok;
    logic            w_mem_we;
    logic [3:0]      w_be;
    logic [31:0]     w_wr_data;
    logic [31:0]     w_rd_word;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [31:0]     w_load_val;
    logic            w_unused_addr;

    // Upper address bits are deliberately ignored so accesses wrap.
    assign w_unused_addr = ^address[31:IdxW+2];

    assign w_req      = memRead | memWrite;
    assign w_addr_bad = ((func3[1:0] == 2'b01) & address[0]) |
                        ((func3[1:0] == 2'b10) & (|address[1:0]));
    assign misaligned = (r_state == S_IDLE) & w_req & w_addr_bad;
    assign w_accept   = (r_state == S_IDLE) & w_req & ~w_addr_bad;
    assign busy       = w_accept | (r_state == S_WAIT);
    assign w_access   = (r_state == S_WAIT) & (r_count == '0);

    assign w_sc_op  = r_is_write & r_sc & (r_func3 == 3'b010);
    assign w_sc_ok  = w_sc_op & r_res_valid & (r_res_addr == r_idx);
    assign w_mem_we = w_access & r_is_write &
                      (w_sc_op ? w_sc_ok : (r_func3 == 3'b000 || r_func3 == 3'b001 ||
                                            r_func3 == 3'b010));

    always_comb begin
        w_be      = 4'b0000;
        w_wr_data = r_wdata;
        unique case (r_func3)
            3'b000: begin
                w_be      = 4'b0001 << r_lane;
                w_wr_data = {4{r_wdata[7:0]}};
            end
            3'b001: begin
                w_be      = r_lane[1] ? 4'b1100 : 4'b0011;
                w_wr_data = {2{r_wdata[15:0]}};
            end
            3'b010: w_be = 4'b1111;
            default: w_be = 4'b0000;
        endcase
    end

    always_comb begin
        w_rd_word  = r_mem[r_idx];
        w_byte     = w_rd_word[{r_lane, 3'b000} +: 8];
        w_half     = r_lane[1] ? w_rd_word[31:16] : w_rd_word[15:0];
        w_load_val = 32'h0;
        unique case (r_func3)
            3'b000:  w_load_val = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load_val = {{16{w_half[15]}}, w_half};
            3'b010:  w_load_val = w_rd_word;
            3'b100:  w_load_val = {24'h0, w_byte};
            3'b101:  w_load_val = {16'h0, w_half};
            default: w_load_val = 32'h0;
        endcase
    end

    // Storage array carries no reset.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (w_mem_we && w_be[b]) begin
                r_mem[r_idx][8*b +: 8] <= w_wr_data[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_count     <= '0;
            r_is_read   <= 1'b0;
            r_is_write  <= 1'b0;
            r_func3     <= 3'b000;
            r_idx       <= '0;
            r_lane      <= 2'b00;
            r_wdata     <= 32'h0;
            r_reserve   <= 1'b0;
            r_sc        <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_addr  <= '0;
            r_rdata     <= 32'h0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (w_accept) begin
                        r_state    <= S_WAIT;
                        r_count    <= CntInit;
                        r_is_read  <= memRead;
                        r_is_write <= memWrite;
                        r_func3    <= func3;
                        r_idx      <= address[IdxW+1:2];
                        r_lane     <= address[1:0];
                        r_wdata    <= writeData;
                        r_reserve  <= reserve;
                        r_sc       <= storeConditional;
                    end
                end
                S_WAIT: begin
                    if (w_access) begin
                        r_state <= S_RESP;
                        r_done  <= 1'b1;
                        if (r_is_write) begin
                            if (w_sc_op) begin
                                r_rdata     <= {31'h0, ~w_sc_ok};
                                r_res_valid <= 1'b0;
                            end else begin
                                if (r_is_read) begin
                                    r_rdata <= 32'h0;
                                end
                                if (r_res_addr == r_idx) begin
                                    r_res_valid <= 1'b0;
                                end
                            end
                        end else begin
                            r_rdata <= w_load_val;
                            if (r_reserve && r_func3 == 3'b010) begin
                                r_res_valid <= 1'b1;
                                r_res_addr  <= r_idx;
                            end
                        end
                    end else begin
                        r_count <= r_count - 1'b1;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign readData = r_rdata;
    assign done     = r_done;

endmodule

// File: tb/tb_data_memory.sv
// Directed plus randomized checks of data_memory against a byte-array reference model.
module tb_data_memory;

    localparam int unsigned DEPTH = 256;
    localparam int unsigned LAT   = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        memRead, memWrite, reserve, storeConditional;
    logic [2:0]  func3;
    logic [31:0] address, writeData;
    logic [31:0] readData;
    logic        busy, done, misaligned;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0]  m_mem [DEPTH*4];
    bit          m_rv;
    int unsigned m_ra;
    logic [31:0] m_last;

    data_memory #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk              (clk),
        .reset            (reset),
        .memRead          (memRead),
        .memWrite         (memWrite),
        .func3            (func3),
        .address          (address),
        .writeData        (writeData),
        .reserve          (reserve),
        .storeConditional (storeConditional),
        .readData         (readData),
        .busy             (busy),
        .done             (done),
        .misaligned       (misaligned)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic bit m_mis(input bit wr, input logic [2:0] f3, input logic [31:0] a);
        bit half, word;
        half = wr ? (f3 == 3'd1) : (f3 == 3'd1 || f3 == 3'd5);
        word = (f3 == 3'd2);
        return (half && a[0]) || (word && a[1:0] != 2'b00);
    endfunction

    task automatic model(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input bit res, input bit sc,
                         output logic [31:0] exp);
        int unsigned idx, base, ln;
        logic [31:0] w;
        idx  = (a >> 2) % DEPTH;
        base = idx * 4;
        ln   = a % 4;
        w    = {m_mem[base+3], m_mem[base+2], m_mem[base+1], m_mem[base]};
        exp  = m_last;
        if (wr) begin
            if (sc && f3 == 3'd2) begin
                if (m_rv && m_ra == idx) begin
                    for (int b = 0; b < 4; b++) m_mem[base+b] = wd[8*b +: 8];
                    exp = 0;
                end else begin
                    exp = 1;
                end
                m_rv = 0;
            end else begin
                if (f3 == 3'd0) m_mem[base+ln] = wd[7:0];
                if (f3 == 3'd1) begin
                    m_mem[base + (ln / 2) * 2]     = wd[7:0];
                    m_mem[base + (ln / 2) * 2 + 1] = wd[15:8];
                end
                if (f3 == 3'd2) for (int b = 0; b < 4; b++) m_mem[base+b] = wd[8*b +: 8];
                if (m_ra == idx) m_rv = 0;
                if (rd) exp = 0;
            end
        end else begin
            case (f3)
                3'd0: exp = 32'($signed(m_mem[base+ln]));
                3'd1: exp = 32'($signed({m_mem[base+(ln/2)*2+1], m_mem[base+(ln/2)*2]}));
                3'd2: exp = w;
                3'd4: exp = {24'h0, m_mem[base+ln]};
                3'd5: exp = {16'h0, m_mem[base+(ln/2)*2+1], m_mem[base+(ln/2)*2]};
                default: exp = 0;
            endcase
            if (res && f3 == 3'd2) begin
                m_rv = 1;
                m_ra = idx;
            end
        end
        m_last = exp;
    endtask

    task automatic idle_inputs();
        memRead = 0; memWrite = 0; reserve = 0; storeConditional = 0;
        func3 = 0; address = 0; writeData = 0;
    endtask

    task automatic do_req(input string tag, input bit rd, input bit wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd, input bit res,
                          input bit sc, output logic [31:0] obs);
        bit mis, seen;
        int cyc;
        logic [31:0] exp;
        mis = m_mis(wr, f3, a);
        @(negedge clk);
        memRead = rd; memWrite = wr; func3 = f3; address = a; writeData = wd;
        reserve = res; storeConditional = sc;
        #1;
        check({tag, "/misaligned"}, 32'(misaligned), 32'(mis));
        check({tag, "/busy0"}, 32'(busy), 32'(!mis));
        obs = readData;
        if (mis) begin
            seen = 0;
            repeat (LAT + 2) begin
                @(posedge clk); #1;
                if (done) seen = 1;
            end
            check({tag, "/no_done"}, 32'(seen), 32'd0);
            idle_inputs();
            return;
        end
        model(rd, wr, f3, a, wd, res, sc, exp);
        cyc = 0; seen = 0;
        while (!seen && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
            if (done) seen = 1;
            else if (busy !== 1'b1) check({tag, "/stall"}, 32'(busy), 32'd1);
        end
        check({tag, "/latency"}, cyc, LAT + 1);
        check({tag, "/busy_resp"}, 32'(busy), 32'd0);
        check({tag, "/rdata"}, readData, exp);
        obs = readData;
        idle_inputs();
        @(posedge clk); #1;
        check({tag, "/done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        logic [31:0] r;
        idle_inputs();
        m_rv = 0; m_ra = 0; m_last = 0;
        reset = 1;
        #12;
        check("reset/rdata", readData, 32'h0);
        check("reset/done", 32'(done), 32'd0);
        check("reset/busy", 32'(busy), 32'd0);
        check("reset/misaligned", 32'(misaligned), 32'd0);
        @(negedge clk); reset = 0;

        for (int i = 0; i < 16; i++) do_req("init", 0, 1, 3'd2, 32'(i * 4), 32'h0, 0, 0, r);

        do_req("sw", 0, 1, 3'd2, 32'h10, 32'hDEADBEEF, 0, 0, r);
        do_req("lw", 1, 0, 3'd2, 32'h10, 0, 0, 0, r);
        check("lw_const", r, 32'hDEADBEEF);
        do_req("sb", 0, 1, 3'd0, 32'h13, 32'h80, 0, 0, r);
        do_req("lb", 1, 0, 3'd0, 32'h13, 0, 0, 0, r);
        check("lb_const", r, 32'hFFFFFF80);
        do_req("lbu", 1, 0, 3'd4, 32'h13, 0, 0, 0, r);
        check("lbu_const", r, 32'h00000080);
        do_req("lw2", 1, 0, 3'd2, 32'h10, 0, 0, 0, r);
        check("lw2_const", r, 32'h80ADBEEF);
        do_req("sh", 0, 1, 3'd1, 32'h12, 32'h1234, 0, 0, r);
        do_req("lw3", 1, 0, 3'd2, 32'h10, 0, 0, 0, r);
        check("lw3_const", r, 32'h1234BEEF);

        do_req("mis_lw", 1, 0, 3'd2, 32'h11, 0, 0, 0, r);
        do_req("mis_lh", 1, 0, 3'd1, 32'h13, 0, 0, 0, r);
        do_req("lw4", 1, 0, 3'd2, 32'h10, 0, 0, 0, r);
        check("lw4_const", r, 32'h1234BEEF);

        do_req("lr1", 1, 0, 3'd2, 32'h20, 0, 1, 0, r);
        do_req("sc1", 0, 1, 3'd2, 32'h20, 32'h55, 0, 1, r);
        check("sc1_const", r, 32'd0);
        do_req("sc2", 0, 1, 3'd2, 32'h20, 32'h66, 0, 1, r);
        check("sc2_const", r, 32'd1);
        do_req("lw_sc", 1, 0, 3'd2, 32'h20, 0, 0, 0, r);
        check("lw_sc_const", r, 32'h55);
        do_req("lr2", 1, 0, 3'd2, 32'h20, 0, 1, 0, r);
        do_req("sw_kill", 0, 1, 3'd2, 32'h20, 32'h77, 0, 0, r);
        do_req("sc3", 0, 1, 3'd2, 32'h20, 32'h99, 0, 1, r);
        check("sc3_const", r, 32'd1);
        do_req("lr3", 1, 0, 3'd2, 32'h20, 0, 1, 0, r);
        do_req("sw_other", 0, 1, 3'd2, 32'h24, 32'h11, 0, 0, r);
        do_req("sc4", 0, 1, 3'd2, 32'h20, 32'hAB, 0, 1, r);
        check("sc4_const", r, 32'd0);

        // Reset during WAIT must abort the store.
        @(negedge clk);
        memWrite = 1; func3 = 3'd2; address = 32'h30; writeData = 32'hAAAA5555;
        @(posedge clk); #1;
        idle_inputs();
        reset = 1;
        #1;
        check("rst_mid/done", 32'(done), 32'd0);
        check("rst_mid/busy", 32'(busy), 32'd0);
        check("rst_mid/rdata", readData, 32'h0);
        @(negedge clk); reset = 0;
        m_rv = 0; m_last = 0;
        do_req("rst_lw", 1, 0, 3'd2, 32'h30, 0, 0, 0, r);
        check("rst_lw_const", r, 32'h0);

        do_req("wrap_sw", 0, 1, 3'd2, 32'h400, 32'h1, 0, 0, r);
        do_req("wrap_lw", 1, 0, 3'd2, 32'h0, 0, 0, 0, r);
        check("wrap_const", r, 32'h1);
        do_req("both", 1, 1, 3'd2, 32'h8, 32'h5A, 0, 0, r);
        check("both_const", r, 32'h0);
        do_req("both_lw", 1, 0, 3'd2, 32'h8, 0, 0, 0, r);
        check("both_lw_const", r, 32'h5A);

        for (int n = 0; n < 200; n++) begin
            int unsigned op;
            logic [2:0]  f3;
            logic [31:0] a;
            bit rd, wr, res, sc;
            op = $urandom_range(0, 4);
            f3 = 3'($urandom_range(0, 7));
            a  = ($urandom & 32'hFFFF_FC00) | ($urandom_range(0, 15) << 2) |
                 32'($urandom_range(0, 3));
            rd = 0; wr = 0; res = 0; sc = 0;
            case (op)
                0: rd = 1;
                1: wr = 1;
                2: begin rd = 1; res = 1; f3 = 3'd2; end
                3: begin wr = 1; sc = 1; f3 = 3'd2; end
                default: begin rd = 1; wr = 1; end
            endcase
            if (wr && f3 > 3'd2) a[1:0] = 2'b00;
            if (!wr && (f3 == 3'd3 || f3 > 3'd5)) a[1:0] = 2'b00;
            do_req("rand", rd, wr, f3, a, $urandom, res, sc, r);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/data_memory.md
# data_memory

Data-memory responder for the core's load/store path. It answers the `memRead`/`memWrite` requests issued by the decode/control stage, which are qualified by `func3`, the address and the store data. It performs byte/halfword/word accesses with sign or zero extension, stalls the pipeline with `busy` for a fixed access latency, and keeps a single LR/SC reservation for the atomic extension.

## Interface
- `DEPTH_WORDS`, 256: number of 32-bit words; power of two, ≥ 4.
- `LATENCY`, 2: wait cycles per access; ≥ 1.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `memRead`  in  1  load request; held by the pipeline until `done`.
- `memWrite`  in  1  store request; held until `done`.
- `func3`  in  3  access width and sign, using RISC-V load/store encoding.
- `address`  in  32  byte address.
- `writeData`  in  32  store data, with the byte/halfword taken from the low bits.
- `reserve`  in  1  qualifies `memRead` as LR.W.
- `storeConditional`  in  1  qualifies `memWrite` as SC.W.
- `readData`  out  32  load result, or SC status (0 = success, 1 = fail).
- `busy`  out  1  stall: the pipeline must not advance.
- `done`  out  1  one-cycle completion pulse.
- `misaligned`  out  1  combinational alignment fault on the current request.

## Operation
- **Request:** req = memRead | memWrite. If both are high, the request is a write and `readData` is set to 0 on completion.
- **Word index:** address[log2(DEPTH_WORDS)+1:2]. Upper address bits are ignored, so accesses wrap.
- **Misalignment:**
  - Halfword access with address[0] = 1, or word access with address[1:0] ≠ 0.
  - `misaligned` = 1 while state is IDLE and req is high.
  - Such a request is never accepted: `busy` = 0, memory and reservation are unchanged, and no `done` is produced.
- **FSM states:** IDLE, WAIT, RESP.
  - IDLE: on an edge with req high and not misaligned, latch the request fields, set count ← LATENCY−1, go to WAIT.
  - WAIT: on each edge, if count = 0, perform the access, set `done` ← 1 and go to RESP; otherwise count ← count−1.
  - RESP: `done` = 1; go to IDLE on the next edge. Requests are not sampled in RESP.
- **busy:** busy = (IDLE & req & ~misaligned) | WAIT. It is low in RESP.
- **Loads** (performed on the WAIT→RESP edge):
  - 000 LB: sign-extend the byte.
  - 001 LH: sign-extend the halfword.
  - 010 LW: full word.
  - 100 LBU: zero-extend the byte.
  - 101 LHU: zero-extend the halfword.
  - Any other `func3`: `readData` = 0.
  - Byte lane is selected by address[1:0]; halfword lane by address[1].
- **Stores:**
  - 000 SB writes writeData[7:0] into the addressed byte.
  - 001 SH writes writeData[15:0] into the addressed halfword.
  - 010 SW writes the full word.
  - Any other `func3`: no write, but the access still completes.
  - For a plain store, `readData` holds its previous value.
- **LR.W** (memRead & reserve & func3 = 010): load the word, set resValid = 1, resAddr = word index.
- **SC.W** (memWrite & storeConditional & func3 = 010):
  - If resValid and resAddr matches: write the word and set `readData` = 0.
  - Otherwise: no write, `readData` = 1.
  - Every SC clears resValid.
- **Reservation clearing:** any plain store to word resAddr clears resValid. Stores to other words leave it intact.
- `readData` holds its value until the next completed load, LR or SC.

## Timing
- **Reset values:** state IDLE, `readData` = 0, `done` = 0, resValid = 0, count = 0. `busy` and `misaligned` follow from these and the inputs.
- **Memory array** is not reset; its contents after power-up are undefined.
- **Cycle sequence** for a request presented in cycle 0 (IDLE):
  - Cycles 0..LATENCY: `busy` = 1.
  - Cycle LATENCY+1: `done` = 1, `busy` = 0, `readData` is valid.
  - Total stall is LATENCY+1 cycles.
- **Memory update** happens only on the WAIT→RESP edge. A reset asserted before that edge aborts the access with no write and no reservation change.
- **Back-to-back:** a new request can be accepted in the first IDLE cycle after RESP. Minimum spacing is LATENCY+2 cycles.
- **Timing paths:** `misaligned` and `busy` are combinational from the inputs. `readData` and `done` are registered.

## Test plan
- **SW/LW round trip, LATENCY = 2:** SW 0xDEADBEEF to 0x10, then LW 0x10 → `busy` high for 3 cycles each, `done` pulses in cycle 3, `readData` = 0xDEADBEEF.
- **Sub-word accesses:** SB 0x80 to 0x13, then LB 0x13 → 0xFFFFFF80; LBU 0x13 → 0x00000080; LW 0x10 → 0x80ADBEEF. Then SH 0x1234 to 0x12 → LW 0x10 = 0x1234BEEF.
- **Misaligned:** LW 0x11 and LH 0x13 → `misaligned` = 1, `busy` = 0, no `done`; a subsequent LW 0x10 is unchanged.
- **LR/SC:**
  - LR 0x20, then SC 0x20 with 0x55 → `readData` = 0, memory = 0x55.
  - A second SC to 0x20 → `readData` = 1, no write.
  - LR 0x20, SW to 0x20, then SC → 1.
  - LR 0x20, SW to 0x24, then SC → 0.
- **Reset mid-access:** start SW 0xAAAA5555 to 0x30 (old value 0), assert `reset` in cycle 1 → state IDLE, `done` = 0, and a later LW 0x30 = 0.
- **Wrap and write priority:** DEPTH_WORDS = 256, SW 0x1 to 0x400 → LW 0x0 = 1. memRead and memWrite high together → the store happens and `readData` = 0.
